otp_auth_core: RTL

Parametrised one-time-password authentication core: captures an OTP word from the LFSR, collects user digits one at a time, compares them, and drives unlock/fail/expiry/lockout status. Sits between `lfsr` and the seven-segment display driver in the top level. It succeeds the fixed 4-digit FSM by adding:
- configurable digit count and width
- an OTP validity window
- an attempt counter with timed lockout
- internal edge detection on the latch buttons

---
 rtl/otp_auth_core_if.sv | 31 +++
 rtl/otp_auth_core.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/otp_auth_core_if.sv
// rtl/otp_auth_core_if.sv - OTP authentication core signal bundle (latches, digits, status)
interface otp_auth_core_if #(
    parameter int DIGITS    = 4,
    parameter int DIGIT_W   = 4,
    parameter int MAX_TRIES = 3
);
    localparam int WORD_W  = DIGITS * DIGIT_W;
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);

    logic [WORD_W-1:0]  lfsr_word;
    logic               otp_latch;
    logic [DIGIT_W-1:0] user_digit;
    logic               user_latch;
    logic [WORD_W-1:0]  otp_out;
    logic [WORD_W-1:0]  user_otp_out;
    logic               unlock;
    logic               fail;
    logic               expired;
    logic               locked;
    logic [TRIES_W-1:0] tries;

    modport master (
        output lfsr_word, otp_latch, user_digit, user_latch,
        input  otp_out, user_otp_out, unlock, fail, expired, locked, tries
    );

    modport slave (
        input  lfsr_word, otp_latch, user_digit, user_latch,
        output otp_out, user_otp_out, unlock, fail, expired, locked, tries
    );
endinterface

// File: rtl/otp_auth_core.sv
// rtl/otp_auth_core.sv - OTP capture, digit entry, compare, expiry and lockout (OTP_AUTH_LOCKOUT_EN)
module otp_auth_core #(
    parameter int DIGITS        = 4,
    parameter int DIGIT_W       = 4,
    parameter int EXPIRE_CYCLES = 1000,
    parameter int MAX_TRIES     = 3,
    parameter int LOCK_CYCLES   = 5000,
    parameter int UNLOCK_CYCLES = 100
) (
    input  logic             clk,
    input  logic             reset,
    otp_auth_core_if.slave   bus
);
    localparam int WORD_W  = DIGITS * DIGIT_W;
    localparam int CNT_W   = $clog2(DIGITS + 1);
    localparam int TMR_W   = $clog2(EXPIRE_CYCLES);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
`ifdef OTP_AUTH_LOCKOUT_EN
    localparam int HOLD_MAX = (LOCK_CYCLES > UNLOCK_CYCLES) ? LOCK_CYCLES : UNLOCK_CYCLES;
`else
    localparam int HOLD_MAX = UNLOCK_CYCLES;
`endif
    localparam int HOLD_W  = $clog2(HOLD_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(DIGITS);
    localparam logic [TMR_W-1:0]  TMR_LAST    = TMR_W'(EXPIRE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] UNLOCK_LAST = HOLD_W'(UNLOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CHECK,
        S_UNLOCKED,
        S_LOCKED
    } state_t;

    state_t             state_q;
    logic               otp_latch_q, user_latch_q;
    logic [WORD_W-1:0]  otp_q, user_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TMR_W-1:0]   timer_q;
    logic [TRIES_W-1:0] tries_q;
    logic [HOLD_W-1:0]  hold_q;
    logic               unlock_q, fail_q, expired_q;
`ifdef OTP_AUTH_LOCKOUT_EN
    localparam logic [HOLD_W-1:0]  LOCK_LAST  = HOLD_W'(LOCK_CYCLES - 1);
    localparam logic [TRIES_W-1:0] TRIES_LAST = TRIES_W'(MAX_TRIES - 1);
    logic               locked_q;
`endif

    logic otp_rise, user_rise;
    assign otp_rise  = bus.otp_latch & ~otp_latch_q;
    assign user_rise = bus.user_latch & ~user_latch_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            otp_latch_q  <= 1'b0;
            user_latch_q <= 1'b0;
            otp_q        <= '0;
            user_q       <= '0;
            cnt_q        <= '0;
            timer_q      <= '0;
            tries_q      <= '0;
            hold_q       <= '0;
            unlock_q     <= 1'b0;
            fail_q       <= 1'b0;
            expired_q    <= 1'b0;
`ifdef OTP_AUTH_LOCKOUT_EN
            locked_q     <= 1'b0;
`endif
        end else begin
            otp_latch_q  <= bus.otp_latch;
            user_latch_q <= bus.user_latch;
            fail_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (otp_rise) begin
                        otp_q     <= bus.lfsr_word;
                        user_q    <= '0;
                        cnt_q     <= '0;
                        timer_q   <= '0;
                        expired_q <= 1'b0;
                        state_q   <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    // Expiry outranks everything, including a re-capture or final digit.
                    if (timer_q == TMR_LAST) begin
                        expired_q <= 1'b1;
                        tries_q   <= '0;
                        state_q   <= S_IDLE;
                    end else if (otp_rise) begin
                        otp_q     <= bus.lfsr_word;
                        user_q    <= '0;
                        cnt_q     <= '0;
                        timer_q   <= '0;
                        expired_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                        if (cnt_q == CNT_FULL) begin
                            state_q <= S_CHECK;
                        end else if (user_rise) begin
                            user_q <= (user_q << DIGIT_W) | WORD_W'(bus.user_digit);
                            cnt_q  <= cnt_q + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (timer_q != TMR_LAST) begin
                        timer_q <= timer_q + 1'b1;
                    end
                    if (user_q == otp_q) begin
                        unlock_q <= 1'b1;
                        hold_q   <= '0;
                        tries_q  <= '0;
                        state_q  <= S_UNLOCKED;
                    end else begin
                        fail_q <= 1'b1;
                        user_q <= '0;
                        cnt_q  <= '0;
`ifdef OTP_AUTH_LOCKOUT_EN
                        tries_q <= tries_q + 1'b1;
                        if (tries_q == TRIES_LAST) begin
                            locked_q <= 1'b1;
                            hold_q   <= '0;
                            state_q  <= S_LOCKED;
                        end else begin
                            state_q <= S_ARMED;
                        end
`else
                        if (tries_q != '1) begin
                            tries_q <= tries_q + 1'b1;
                        end
                        state_q <= S_ARMED;
`endif
                    end
                end
                S_UNLOCKED: begin
                    if (hold_q == UNLOCK_LAST) begin
                        unlock_q <= 1'b0;
                        hold_q   <= '0;
                        state_q  <= S_IDLE;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
`ifdef OTP_AUTH_LOCKOUT_EN
                S_LOCKED: begin
                    if (hold_q == LOCK_LAST) begin
                        locked_q <= 1'b0;
                        tries_q  <= '0;
                        hold_q   <= '0;
                        state_q  <= S_IDLE;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.otp_out      = otp_q;
    assign bus.user_otp_out = user_q;
    assign bus.unlock       = unlock_q;
    assign bus.fail         = fail_q;
    assign bus.expired      = expired_q;
    assign bus.tries        = tries_q;
`ifdef OTP_AUTH_LOCKOUT_EN
    assign bus.locked       = locked_q;
`else
    assign bus.locked       = 1'b0;
`endif
endmodule
